// File: rtl/misr_pkg.sv
// Shared types, default constants and the MISR update function for the
// output signature compactor.
package misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_t;

    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

    // Values up to 64 bits wide; only the low `width` bits are meaningful.
    function automatic logic [63:0] misr_step(input logic [63:0] m,
                                              input logic [63:0] f,
                                              input logic [63:0] poly,
                                              input int          width);
        logic [63:0] mask;
        logic [63:0] r;
        mask = {64{1'b1}} >> (64 - width);
        r    = (m << 1) & mask;
        if (((m >> (width - 1)) & 64'd1) != 64'd0) begin
            r = r ^ poly;
        end
        return (r ^ f) & mask;
    endfunction

endpackage

// File: rtl/output_misr_compactor_if.sv
// Capture/handshake bundle between a benchmark wrapper and the compactor.
interface output_misr_compactor_if #(
    parameter int DATA_WIDTH = 64,
    parameter int SIG_WIDTH  = 32
);
    logic                  start;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  busy;
    logic                  sig_valid;
    logic [SIG_WIDTH-1:0]  signature;
    logic                  serial_out;

    modport master (
        output start, data_valid, data_in,
        input  busy, sig_valid, signature, serial_out
    );

    modport slave (
        input  start, data_valid, data_in,
        output busy, sig_valid, signature, serial_out
    );
endinterface

// File: rtl/output_misr_compactor_xor_fold.sv
// Zero-pads the input bus to whole SIG_WIDTH chunks and XORs the chunks together.
module xor_fold #(
    parameter int DATA_WIDTH = 64,
    parameter int SIG_WIDTH  = 32
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [SIG_WIDTH-1:0]  o_fold
);
    localparam int NCHUNK = (DATA_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
    localparam int PW     = NCHUNK * SIG_WIDTH;

    logic [PW-1:0] w_padded;

    assign w_padded = PW'(i_data);

    always_comb begin
        o_fold = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            o_fold = o_fold ^ w_padded[i*SIG_WIDTH +: SIG_WIDTH];
        end
    end
endmodule

// File: rtl/output_misr_compactor.sv
// Absorbs WINDOW valid beats into a MISR, then holds the signature and
// rotates it out MSB first on serial_out.
module output_misr_compactor
    import misr_pkg::*;
#(
    parameter int                  DATA_WIDTH = 64,
    parameter int                  SIG_WIDTH  = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEF_POLY),
    parameter logic [SIG_WIDTH-1:0] SEED      = SIG_WIDTH'(DEF_SEED),
    parameter int                  WINDOW     = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    output_misr_compactor_if.slave  bus
);
    localparam int CW = $clog2(WINDOW + 1);

    misr_state_t          r_state;
    misr_state_t          w_state_nxt;
    logic [SIG_WIDTH-1:0] r_misr;
    logic [CW-1:0]        r_count;
    logic [SIG_WIDTH-1:0] r_signature;
    logic [SIG_WIDTH-1:0] r_shift;
    logic                 r_busy;
    logic                 r_sig_valid;

    logic [SIG_WIDTH-1:0] w_fold;
    logic [SIG_WIDTH-1:0] w_step;
    logic                 w_load_seed;
    logic                 w_absorb;
    logic                 w_finish;

    xor_fold #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIG_WIDTH  (SIG_WIDTH)
    ) u_fold (
        .i_data (bus.data_in),
        .o_fold (w_fold)
    );

    assign w_step = SIG_WIDTH'(misr_step(64'(r_misr), 64'(w_fold), 64'(POLY), SIG_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start has priority over data, so the start cycle never absorbs a beat.
    always_comb begin
        w_state_nxt = r_state;
        w_load_seed = 1'b0;
        w_absorb    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_load_seed = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.start) begin
                    w_load_seed = 1'b1;
                end else if (bus.data_valid) begin
                    w_absorb = 1'b1;
                    if (r_count == CW'(WINDOW - 1)) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_load_seed = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misr      <= '0;
            r_count     <= '0;
            r_signature <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_sig_valid <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt == ST_RUN);
            r_sig_valid <= (w_state_nxt == ST_DONE);
            if (w_load_seed) begin
                r_misr  <= SEED;
                r_count <= '0;
            end else if (w_absorb) begin
                r_misr  <= w_step;
                r_count <= r_count + CW'(1);
            end
            if (w_finish) begin
                r_signature <= w_step;
                r_shift     <= w_step;
            end else if (r_state == ST_DONE) begin
                r_shift <= {r_shift[SIG_WIDTH-2:0], r_shift[SIG_WIDTH-1]};
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.sig_valid  = r_sig_valid;
    assign bus.signature  = r_signature;
    assign bus.serial_out = r_shift[SIG_WIDTH-1];
endmodule

// File: tb/tb_output_misr_compactor.sv
// Scoreboard bench for output_misr_compactor: four instances with different
// SEED/WINDOW share one stimulus stream; each scenario checks one of them.
module tb_output_misr_compactor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        tb_reset;
    logic        tb_start;
    logic        tb_valid;
    logic [63:0] tb_data;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    output_misr_compactor_if #(.DATA_WIDTH(64), .SIG_WIDTH(32)) if_a ();
    output_misr_compactor_if #(.DATA_WIDTH(64), .SIG_WIDTH(32)) if_b ();
    output_misr_compactor_if #(.DATA_WIDTH(64), .SIG_WIDTH(32)) if_c ();
    output_misr_compactor_if #(.DATA_WIDTH(64), .SIG_WIDTH(32)) if_d ();

    assign if_a.start = tb_start; assign if_a.data_valid = tb_valid; assign if_a.data_in = tb_data;
    assign if_b.start = tb_start; assign if_b.data_valid = tb_valid; assign if_b.data_in = tb_data;
    assign if_c.start = tb_start; assign if_c.data_valid = tb_valid; assign if_c.data_in = tb_data;
    assign if_d.start = tb_start; assign if_d.data_valid = tb_valid; assign if_d.data_in = tb_data;

    output_misr_compactor #(.SEED(32'h0), .WINDOW(1))
        dut_a (.clk(clk), .reset(tb_reset), .bus(if_a));
    output_misr_compactor #(.SEED(32'h0), .WINDOW(2))
        dut_b (.clk(clk), .reset(tb_reset), .bus(if_b));
    output_misr_compactor #(.SEED(32'h80000000), .WINDOW(1))
        dut_c (.clk(clk), .reset(tb_reset), .bus(if_c));
    output_misr_compactor #(.WINDOW(4))
        dut_d (.clk(clk), .reset(tb_reset), .bus(if_d));

    int          sel;
    logic        sel_busy, sel_sv, sel_so;
    logic [31:0] sel_sig;

    always_comb begin
        sel_busy = 1'b0; sel_sv = 1'b0; sel_so = 1'b0; sel_sig = '0;
        case (sel)
            0: begin sel_busy = if_a.busy; sel_sv = if_a.sig_valid; sel_so = if_a.serial_out; sel_sig = if_a.signature; end
            1: begin sel_busy = if_b.busy; sel_sv = if_b.sig_valid; sel_so = if_b.serial_out; sel_sig = if_b.signature; end
            2: begin sel_busy = if_c.busy; sel_sv = if_c.sig_valid; sel_so = if_c.serial_out; sel_sig = if_c.signature; end
            default: begin sel_busy = if_d.busy; sel_sv = if_d.sig_valid; sel_so = if_d.serial_out; sel_sig = if_d.signature; end
        endcase
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mstep(input logic [31:0] m, input logic [63:0] d);
        logic [31:0] r;
        r = {m[30:0], 1'b0};
        if (m[31]) r = r ^ POLY;
        return r ^ d[31:0] ^ d[63:32];
    endfunction

    task automatic drive(input logic st, input logic v, input logic [63:0] d);
        tb_start = st; tb_valid = v; tb_data = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_sig(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, sel_sig, e);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, sel_busy, 0);
        chk({tag, "_sv"},   sel_sv,   0);
        chk({tag, "_sig"},  sel_sig,  0);
        chk({tag, "_so"},   sel_so,   0);
    endtask

    initial begin
        logic [31:0] m;
        logic [31:0] esig;
        logic [63:0] d;
        logic [6:0]  pat;
        int          bcnt;

        sel = 0;
        tb_reset = 1'b1;
        drive(0, 0, '0);
        tick(); tick();
        tb_reset = 1'b0;
        check_zero("reset");

        // WINDOW=1, SEED=0: start cycle carries a valid beat that must be ignored.
        sel = 0;
        exp_q.push_back(32'h00000001);
        drive(1, 1, 64'hFFFF_FFFF_0000_FFFF);
        tick();
        chk("t1_busy", sel_busy, 1);
        chk("t1_sv_early", sel_sv, 0);
        drive(0, 1, 64'h1);
        tick();
        drive(0, 1, 64'hDEAD_BEEF_1234_5678);
        chk("t1_sv", sel_sv, 1);
        chk("t1_busy_off", sel_busy, 0);
        esig = 32'h00000001;
        check_sig("t1_sig");
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("t1_so%0d", i), sel_so, esig[31 - (i % 32)]);
            tick();
        end
        chk("t1_sig_hold", sel_sig, 32'h00000001);

        // WINDOW=2: upper chunk folds in, then a plain shift.
        tb_reset = 1'b1; drive(0, 0, '0); tick(); tb_reset = 1'b0;
        sel = 1;
        exp_q.push_back(32'h00000002);
        drive(1, 0, '0); tick();
        drive(0, 1, 64'h00000001_00000000); tick();
        chk("t2_sv_mid", sel_sv, 0);
        drive(0, 1, 64'h0); tick();
        drive(0, 0, '0);
        chk("t2_sv", sel_sv, 1);
        check_sig("t2_sig");

        // Feedback path from SEED MSB.
        sel = 2;
        exp_q.push_back(32'h04C11DB7);
        drive(1, 0, '0); tick();
        drive(0, 1, 64'h0); tick();
        drive(0, 0, '0);
        chk("t3_sv", sel_sv, 1);
        check_sig("t3_sig");

        // WINDOW=4 with gaps; invalid cycles carry random data.
        sel = 3;
        pat = 7'b1011001;
        m = 32'hFFFFFFFF;
        bcnt = 0;
        drive(1, 0, '0); tick();
        for (int i = 0; i < 7; i++) begin
            if (sel_busy) bcnt++;
            d = {$urandom, $urandom};
            if (pat[i]) m = mstep(m, d);
            drive(0, pat[i], d);
            tick();
        end
        exp_q.push_back(m);
        drive(0, 0, '0);
        chk("t4_busy_cycles", bcnt, 7);
        chk("t4_busy_off", sel_busy, 0);
        chk("t4_sv", sel_sv, 1);
        check_sig("t4_sig");

        // Restart after 2 of 4 beats; only the last 4 beats count.
        drive(1, 0, '0); tick();
        drive(0, 1, 64'h1111_2222_3333_4444); tick();
        drive(0, 1, 64'h5555_6666_7777_8888); tick();
        drive(1, 1, 64'hAAAA_AAAA_AAAA_AAAA); tick();
        m = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_sv_pre%0d", i), sel_sv, 0);
            d = {$urandom, $urandom};
            m = mstep(m, d);
            drive(0, 1, d);
            tick();
        end
        exp_q.push_back(m);
        drive(0, 0, '0);
        chk("t5_sv", sel_sv, 1);
        check_sig("t5_sig");

        // Reset while in RUN.
        drive(1, 0, '0); tick();
        drive(0, 1, 64'h1234); tick();
        chk("t6_busy_run", sel_busy, 1);
        tb_reset = 1'b1; drive(0, 1, 64'h5678); tick(); tb_reset = 1'b0;
        drive(0, 0, '0);
        check_zero("t6_rst_run");

        // Reset while in DONE, then a cold start.
        sel = 0;
        drive(1, 0, '0); tick();
        drive(0, 1, 64'h0000_0000_FFFF_FFFF); tick();
        drive(0, 0, '0);
        chk("t7_sv", sel_sv, 1);
        chk("t7_so", sel_so, 1);
        tb_reset = 1'b1; tick(); tb_reset = 1'b0;
        check_zero("t7_rst_done");
        exp_q.push_back(32'h00000001);
        drive(1, 0, '0); tick();
        drive(0, 1, 64'h1);
        bcnt = 0;
        while (!sel_sv && bcnt < 20) begin
            tick();
            drive(0, 0, '0);
            bcnt++;
        end
        chk("t7_cold_latency", bcnt, 1);
        check_sig("t7_cold_sig");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/output_misr_compactor.md
# output_misr_compactor

Compacts the wide internal outputs of a benchmark core into a 32-bit multiple-input signature register (MISR) signature exposed on a few pins. Sits directly downstream of the random-stimulus benchmark wrappers, so synthesis cannot prune the core's otherwise unobserved buses (SRAM address/data/WE, video RGB, depth). Captures a fixed window of valid beats, then holds and serially shifts out the signature.

## Interface
- DATA_WIDTH, 64, width of compacted input bus; any value ≥1.
- SIG_WIDTH, 32, MISR/signature width; 2..64.
- POLY, 32'h04C11DB7, feedback polynomial (taps), SIG_WIDTH bits.
- SEED, 32'hFFFFFFFF, MISR value loaded on start.
- WINDOW, 1024, number of valid beats per capture; ≥1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse: (re)arm and begin a capture window.
- data_valid  in  1  data_in is a beat to absorb this cycle.
- data_in  in  DATA_WIDTH  concatenated core outputs.
- busy  out  1  high while in RUN.
- sig_valid  out  1  high while in DONE.
- signature  out  SIG_WIDTH  final signature; stable throughout DONE.
- serial_out  out  1  signature bit stream, MSB first, rotating.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start → RUN; MISR ← SEED, beat count ← 0.
- RUN: each cycle with data_valid=1 absorbs one beat and increments the beat count. Cycles with data_valid=0 leave the MISR and the count unchanged.
- Fold: data_in is zero-padded to a multiple of SIG_WIDTH. Its SIG_WIDTH-bit chunks are XORed together, giving `f`.
- MISR step: `m' = {m[SIG_WIDTH-2:0],1'b0} ^ (m[SIG_WIDTH-1] ? POLY : 0) ^ f`.
- When the absorbed beat is the WINDOW-th, the next state is DONE:
  - signature ← m' (includes that beat);
  - the serial shift register is loaded with m';
  - bit index ← 0.
- DONE:
  - serial_out = shift-register MSB;
  - the shift register rotates left by 1 every cycle, so the period is SIG_WIDTH;
  - data_valid is ignored;
  - start → RUN with a fresh SEED and count.
- start while in RUN restarts the capture: MISR ← SEED, count ← 0, state stays RUN.
- The start cycle never absorbs data, even if data_valid=1 in that cycle.
- Beat counter width: $clog2(WINDOW+1). It never wraps, because the terminal beat exits RUN.
- Reset mid-operation, from any state: IDLE, all registers cleared, serial_out=0 next cycle.

## Timing
- Reset values: busy=0, sig_valid=0, signature=0, serial_out=0, MISR=0, count=0.
- start at edge N: busy=1 from N+1.
- WINDOW-th valid beat at edge K: busy=0 and sig_valid=1 from K+1, with signature valid in the same cycle.
- serial_out at K+1 is signature MSB; at K+1+i it is bit SIG_WIDTH-1-(i mod SIG_WIDTH).
- All outputs are registered; there is no combinational path from any input to any output.
- Throughput: one beat per cycle; back-to-back valid beats are fully supported.

## Structure
- Package misr_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - default POLY/SEED constants;
  - pure function misr_step(m, f, poly).
- Sub-module xor_fold: parameterised DATA_WIDTH→SIG_WIDTH chunk-XOR fold, combinational, instanced once.
- Top-level benchmark wrappers instantiate output_misr_compactor, with the concatenated unobserved buses on data_in and data_valid tied high.

## Test plan
- SEED=0, WINDOW=1, data_in=64'h1 → sig_valid at the cycle after the beat, signature=32'h00000001. serial_out is 0 for 31 cycles, then 1, then the pattern repeats.
- SEED=0, WINDOW=2, beats 64'h00000001_00000000 then 64'h0 → signature=32'h00000002 (fold of the upper chunk, then a shift).
- SEED=32'h80000000, WINDOW=1, data_in=0 → signature=32'h04C11DB7 (feedback path).
- WINDOW=4, data_valid toggling 1,0,0,1,1,0,1 → busy spans exactly 7 cycles. signature equals the model's 4-step result; the invalid cycles have no effect.
- start re-asserted after 2 of 4 beats → count and MISR restart from SEED; DONE arrives only after 4 further beats.
- reset asserted in RUN and in DONE → next cycle: IDLE, busy=0, sig_valid=0, signature=0, serial_out=0; a subsequent start behaves as from cold.
